alu_ctrl_unit: RTL and testbench
================================

Name: alu_ctrl_unit

Overview:
- RV32I execute-stage block: decodes opcode/funct3/funct7_bit into datapath control signals and a 4-bit ALU operation.
- Executes that operation on two 32-bit operands.
- All outputs are registered, giving a single-stage, one-cycle-latency unit between decode and memory/writeback.
- Contains two functions: the decoder (control unit) and the arithmetic unit (ALU).

Parameters:
- XLEN, 32, operand/result width (only 32 is supported).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  inputs valid this cycle
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7_bit  in  1  instruction[30]
- operand_a  in  32  rs1 value
- operand_b  in  32  rs2 value or immediate, selected upstream
- out_valid  out  1  registered copy of in_valid
- alu_src  out  1  operand B is the immediate
- mem_to_reg  out  1  writeback from memory
- reg_write  out  1  write rd
- mem_read  out  1  load
- mem_write  out  1  store
- branch  out  1  conditional branch
- jump  out  1  JAL/JALR
- alu_control  out  4  ALU operation code
- result  out  32  ALU result
- zero_flag  out  1  result == 0

Behaviour:
- Reset (rst_n=0, asynchronous): every output register is cleared to 0.
  - The 0 value of zero_flag is the register value; it is not derived from result.
- Latency:
  - When in_valid=1, decode and ALU operate combinationally.
  - At the next rising clk all outputs update and out_valid=1.
  - When in_valid=0, out_valid goes 0 and the other outputs hold their previous values.
- ALU codes ({funct7_bit,funct3} style):
  - 0000 ADD
  - 1000 SUB
  - 0001 SLL
  - 0010 SLT (signed)
  - 0011 SLTU
  - 0100 XOR
  - 0101 SRL
  - 1101 SRA
  - 0110 OR
  - 0111 AND
  - 1111 PASS_B
  - Any other code yields result 0.
- Arithmetic rules:
  - Add/sub wrap modulo 2^32.
  - Shift amount is operand_b[4:0].
  - SLT/SLTU produce 32'd1 or 32'd0.
  - zero_flag = (result == 0).
- Decode by opcode (signals not listed are 0):
  - 0110011 R-type: reg_write=1; alu_control={funct7_bit,funct3}. funct7_bit is ignored unless funct3 is 000 or 101.
  - 0010011 I-ALU: alu_src=1, reg_write=1; alu_control={0,funct3}, except funct3=101 uses {funct7_bit,101}. ADDI never becomes SUB.
  - 0000011 load: alu_src, mem_to_reg, reg_write, mem_read = 1; ADD.
  - 0100011 store: alu_src=1, mem_write=1; ADD.
  - 1100011 branch: branch=1.
    - funct3 00x → SUB
    - 10x → SLT
    - 11x → SLTU
  - 1101111 JAL: jump=1, reg_write=1; ADD.
  - 1100111 JALR: jump=1, reg_write=1, alu_src=1; ADD.
  - 0110111 LUI: reg_write=1, alu_src=1; PASS_B.
  - 0010111 AUIPC: reg_write=1, alu_src=1; ADD.
  - Any other opcode: all control outputs 0; ADD.
- Reset asserted mid-operation: the in-flight result is discarded and outputs go to 0 immediately. The first capture after rst_n deasserts happens on the next rising clk with in_valid=1.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - ALU code constants (ALU_ADD ... ALU_PASS_B)
- One combinational sub-module, alu_core, containing ALU codes → result.
- Decode and the output register stage live in the top.

Test Plan:
- R ADD: opcode 0110011, f3 000, f7 0, a=10, b=5 → after 1 clk: result 15, alu_control 0000, reg_write 1, alu_src 0, out_valid 1.
- R SUB/AND:
  - f7 1, a=10, b=5 → result 5, code 1000, zero 0.
  - f3 111, a=10, b=5 → result 0, code 0111, zero_flag 1.
- I ADDI/ANDI:
  - opcode 0010011, f3 000, f7 1, a=7, b=8 → result 15, code 0000, alu_src 1.
  - f3 111, a=12, b=5 → result 4.
- Shifts/compare:
  - SRAI a=0x80000000, b=4, f7 1 → 0xF8000000.
  - SLT a=-1, b=1 → 1.
  - SLTU same operands → 0.
- Control: load → mem_read, mem_to_reg, reg_write, alu_src = 1; store → mem_write=1, reg_write=0; BEQ a=b=3 → branch 1, zero 1; opcode 1111111 → all control 0.
- Reset/valid:
  - rst_n low mid-stream → all outputs 0 asynchronously.
  - in_valid 0 → out_valid 0 with outputs held.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the RV32I execute-stage decoder and ALU.
package alu_ctrl_pkg;

  localparam int XLEN = 32;

  // Major opcodes, instruction[6:0]
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operation codes, laid out as {funct7_bit, funct3}
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_SLL    = 4'b0001;
  localparam logic [3:0] ALU_SLT    = 4'b0010;
  localparam logic [3:0] ALU_SLTU   = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_SRA    = 4'b1101;
  localparam logic [3:0] ALU_OR     = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  // Datapath control bundle produced by the decoder
  typedef struct packed {
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_unit_alu_core.sv
// Purely combinational 32-bit ALU: operation code in, result out.
module alu_core
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      alu_control_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // Select the operation; unused codes produce zero.
  always_comb begin
    result_o = '0;
    case (alu_control_i)
      ALU_ADD:    result_o = a_i + b_i;
      ALU_SUB:    result_o = a_i - b_i;
      ALU_SLL:    result_o = a_i << shamt;
      ALU_SLT:    result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU:   result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:    result_o = a_i ^ b_i;
      ALU_SRL:    result_o = a_i >> shamt;
      ALU_SRA:    result_o = $signed(a_i) >>> shamt;
      ALU_OR:     result_o = a_i | b_i;
      ALU_AND:    result_o = a_i & b_i;
      ALU_PASS_B: result_o = b_i;
      default:    result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_unit.sv
// RV32I execute stage: decode opcode/funct fields, run the ALU, and
// register every output for a fixed one-cycle latency.
//
// Handshake: in_valid qualifies the inputs in the cycle it is high; there
// is no ready (the unit never stalls). out_valid is in_valid delayed by one
// clock. When in_valid is low, out_valid drops and all other outputs keep
// the last captured values.
module alu_ctrl_unit
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_bit,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  output logic            alu_src,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic            zero_flag
);

  ctrl_t           ctrl_d, ctrl_q;
  logic [3:0]      alu_code_d, alu_code_q;
  logic [XLEN-1:0] result_d, result_q;
  logic            zero_d, zero_q;
  logic            valid_q;

  // Decode opcode/funct fields into control signals and an ALU code.
  always_comb begin
    ctrl_d     = '0;
    alu_code_d = ALU_ADD;
    case (opcode)
      OP_R: begin
        ctrl_d.reg_write = 1'b1;
        // Only ADD/SUB and SRL/SRA are distinguished by funct7 bit 30.
        if (funct3 == 3'b000 || funct3 == 3'b101) alu_code_d = {funct7_bit, funct3};
        else                                      alu_code_d = {1'b0, funct3};
      end
      OP_IMM: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        // Bit 30 of an I-type is immediate data except for SRLI/SRAI,
        // so ADDI can never turn into SUB.
        if (funct3 == 3'b101) alu_code_d = {funct7_bit, 3'b101};
        else                  alu_code_d = {1'b0, funct3};
      end
      OP_LOAD: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_read   = 1'b1;
      end
      OP_STORE: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_d.branch = 1'b1;
        // BEQ/BNE compare via SUB + zero; BLT/BGE via SLT; BLTU/BGEU via SLTU.
        // The reserved 01x encodings fall back to SUB.
        case (funct3[2:1])
          2'b10:   alu_code_d = ALU_SLT;
          2'b11:   alu_code_d = ALU_SLTU;
          default: alu_code_d = ALU_SUB;
        endcase
      end
      OP_JAL: begin
        ctrl_d.jump      = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      OP_JALR: begin
        ctrl_d.jump      = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_LUI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        alu_code_d       = ALU_PASS_B;
      end
      OP_AUIPC: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      default: begin
        ctrl_d     = '0;
        alu_code_d = ALU_ADD;
      end
    endcase
  end

  alu_core #(.XLEN(XLEN)) u_alu_core (
    .a_i           (operand_a),
    .b_i           (operand_b),
    .alu_control_i (alu_code_d),
    .result_o      (result_d)
  );

  assign zero_d = (result_d == '0);

  // Output register stage: capture on valid input, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      alu_code_q <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        ctrl_q     <= ctrl_d;
        alu_code_q <= alu_code_d;
        result_q   <= result_d;
        zero_q     <= zero_d;
      end
    end
  end

  assign out_valid   = valid_q;
  assign alu_src     = ctrl_q.alu_src;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign reg_write   = ctrl_q.reg_write;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign branch      = ctrl_q.branch;
  assign jump        = ctrl_q.jump;
  assign alu_control = alu_code_q;
  assign result      = result_q;
  assign zero_flag   = zero_q;

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed, table-driven bench for alu_ctrl_unit with hand-computed vectors
// and a few hand-written reset/valid sequences.
module tb_alu_ctrl_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_bit = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        out_valid, alu_src, mem_to_reg, reg_write, mem_read;
  logic        mem_write, branch, jump, zero_flag;
  logic [3:0]  alu_control;
  logic [31:0] result;

  alu_ctrl_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_bit (funct7_bit),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .out_valid  (out_valid),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .branch     (branch),
    .jump       (jump),
    .alu_control(alu_control),
    .result     (result),
    .zero_flag  (zero_flag)
  );

  // Control bundle order: {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump}
  logic [6:0] act_ctrl;
  assign act_ctrl = {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_RW   = 7'b0010000;
  localparam logic [6:0] C_IMM  = 7'b1010000;
  localparam logic [6:0] C_LD   = 7'b1111000;
  localparam logic [6:0] C_ST   = 7'b1000100;
  localparam logic [6:0] C_BR   = 7'b0000010;
  localparam logic [6:0] C_JAL  = 7'b0010001;
  localparam logic [6:0] C_JALR = 7'b1010001;

  localparam logic [6:0] O_R   = 7'b0110011;
  localparam logic [6:0] O_I   = 7'b0010011;
  localparam logic [6:0] O_LD  = 7'b0000011;
  localparam logic [6:0] O_ST  = 7'b0100011;
  localparam logic [6:0] O_BR  = 7'b1100011;
  localparam logic [6:0] O_JAL = 7'b1101111;
  localparam logic [6:0] O_JR  = 7'b1100111;
  localparam logic [6:0] O_LUI = 7'b0110111;
  localparam logic [6:0] O_AUI = 7'b0010111;
  localparam logic [6:0] O_BAD = 7'b1111111;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  ctrl;
    logic [3:0]  code;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(string n, logic [6:0] op, logic [2:0] f3, logic f7,
                              logic [31:0] a, logic [31:0] b, logic [6:0] ctrl,
                              logic [3:0] code, logic [31:0] res, logic zero);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
    v.ctrl = ctrl; v.code = code; v.res = res; v.zero = zero;
    return v;
  endfunction

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", what, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v, input logic vld);
    @(negedge clk);
    in_valid   = vld;
    opcode     = v.op;
    funct3     = v.f3;
    funct7_bit = v.f7;
    operand_a  = v.a;
    operand_b  = v.b;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] exp_res;
    drive(v, 1'b1);
    exp_q.push_back(v.res);
    @(posedge clk);
    #1;
    exp_res = exp_q.pop_front();
    check({v.name, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({v.name, ".ctrl"},  {25'b0, act_ctrl}, {25'b0, v.ctrl});
    check({v.name, ".code"},  {28'b0, alu_control}, {28'b0, v.code});
    check({v.name, ".result"}, result, exp_res);
    check({v.name, ".zero"},  {31'b0, zero_flag}, {31'b0, v.zero});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},  {31'b0, out_valid}, 32'd0);
    check({tag, ".ctrl"},   {25'b0, act_ctrl}, 32'd0);
    check({tag, ".code"},   {28'b0, alu_control}, 32'd0);
    check({tag, ".result"}, result, 32'd0);
    check({tag, ".zero"},   {31'b0, zero_flag}, 32'd0);
  endtask

  // Watchdog: the run is purely clock-counted, but never let it hang.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hold_v;
    // ---------------- vector table ----------------
    vecs.push_back(mk("r_add",  O_R, 3'b000, 1'b0, 32'd10, 32'd5, C_RW, 4'b0000, 32'd15, 1'b0));
    vecs.push_back(mk("r_sub",  O_R, 3'b000, 1'b1, 32'd10, 32'd5, C_RW, 4'b1000, 32'd5, 1'b0));
    vecs.push_back(mk("r_and",  O_R, 3'b111, 1'b0, 32'd10, 32'd5, C_RW, 4'b0111, 32'd0, 1'b1));
    vecs.push_back(mk("r_subwrap", O_R, 3'b000, 1'b1, 32'd0, 32'd1, C_RW, 4'b1000, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk("r_sll",  O_R, 3'b001, 1'b0, 32'd1, 32'd33, C_RW, 4'b0001, 32'd2, 1'b0));
    vecs.push_back(mk("r_slt",  O_R, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, C_RW, 4'b0010, 32'd1, 1'b0));
    vecs.push_back(mk("r_sltu", O_R, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, C_RW, 4'b0011, 32'd0, 1'b1));
    vecs.push_back(mk("r_slt_f7", O_R, 3'b010, 1'b1, 32'hFFFF_FFFF, 32'd1, C_RW, 4'b0010, 32'd1, 1'b0));
    vecs.push_back(mk("r_xor",  O_R, 3'b100, 1'b0, 32'hFF, 32'h0F, C_RW, 4'b0100, 32'hF0, 1'b0));
    vecs.push_back(mk("r_srl",  O_R, 3'b101, 1'b0, 32'h8000_0000, 32'd4, C_RW, 4'b0101, 32'h0800_0000, 1'b0));
    vecs.push_back(mk("r_or",   O_R, 3'b110, 1'b1, 32'hF0, 32'h0F, C_RW, 4'b0110, 32'hFF, 1'b0));
    vecs.push_back(mk("i_addi_f7", O_I, 3'b000, 1'b1, 32'd7, 32'd8, C_IMM, 4'b0000, 32'd15, 1'b0));
    vecs.push_back(mk("i_andi", O_I, 3'b111, 1'b0, 32'd12, 32'd5, C_IMM, 4'b0111, 32'd4, 1'b0));
    vecs.push_back(mk("i_srai", O_I, 3'b101, 1'b1, 32'h8000_0000, 32'd4, C_IMM, 4'b1101, 32'hF800_0000, 1'b0));
    vecs.push_back(mk("i_srli", O_I, 3'b101, 1'b0, 32'h8000_0000, 32'd4, C_IMM, 4'b0101, 32'h0800_0000, 1'b0));
    vecs.push_back(mk("load",   O_LD, 3'b010, 1'b0, 32'd100, 32'd4, C_LD, 4'b0000, 32'd104, 1'b0));
    vecs.push_back(mk("store",  O_ST, 3'b010, 1'b1, 32'd100, 32'd8, C_ST, 4'b0000, 32'd108, 1'b0));
    vecs.push_back(mk("beq",    O_BR, 3'b000, 1'b0, 32'd3, 32'd3, C_BR, 4'b1000, 32'd0, 1'b1));
    vecs.push_back(mk("blt",    O_BR, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, C_BR, 4'b0010, 32'd1, 1'b0));
    vecs.push_back(mk("bgeu",   O_BR, 3'b111, 1'b0, 32'd1, 32'd2, C_BR, 4'b0011, 32'd1, 1'b0));
    vecs.push_back(mk("jal",    O_JAL, 3'b000, 1'b0, 32'h100, 32'd4, C_JAL, 4'b0000, 32'h104, 1'b0));
    vecs.push_back(mk("jalr",   O_JR, 3'b000, 1'b1, 32'h200, 32'd12, C_JALR, 4'b0000, 32'h20C, 1'b0));
    vecs.push_back(mk("lui",    O_LUI, 3'b101, 1'b1, 32'hDEAD, 32'h1234_5000, C_IMM, 4'b1111, 32'h1234_5000, 1'b0));
    vecs.push_back(mk("auipc",  O_AUI, 3'b000, 1'b0, 32'h1000, 32'h2000, C_IMM, 4'b0000, 32'h3000, 1'b0));
    vecs.push_back(mk("bad_op", O_BAD, 3'b111, 1'b1, 32'd5, 32'd5, C_NONE, 4'b0000, 32'd10, 1'b0));

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("post_reset_idle");

    // ---------------- table-driven vectors ----------------
    foreach (vecs[i]) run_vec(vecs[i]);

    // ---------------- valid low holds outputs ----------------
    run_vec(vecs[0]);  // r_add -> 15
    hold_v = mk("hold", O_ST, 3'b000, 1'b1, 32'd99, 32'd1, C_ST, 4'b1000, 32'd0, 1'b0);
    drive(hold_v, 1'b0);
    @(posedge clk);
    #1;
    check("hold.valid",  {31'b0, out_valid}, 32'd0);
    check("hold.ctrl",   {25'b0, act_ctrl}, {25'b0, C_RW});
    check("hold.code",   {28'b0, alu_control}, 32'd0);
    check("hold.result", result, 32'd15);
    check("hold.zero",   {31'b0, zero_flag}, 32'd0);

    // ---------------- async reset mid-stream ----------------
    run_vec(vecs[15]);  // load, several control bits set
    drive(vecs[16], 1'b1);  // store in flight
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("rst_release_idle");
    run_vec(vecs[13]);  // srai captured after reset

    @(negedge clk);
    in_valid = 1'b0;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
